// File: rtl/hdb3_pkg.sv
// Shared HDB3 definitions: ternary symbol codes, pipeline mark
// encoding and pulse polarity, used by the encoder and the decoder.
package hdb3_pkg;

  // Ternary line symbols carried on the 2-bit HDB3 code bus.
  localparam logic [1:0] HDB3_ZERO = 2'b00;
  localparam logic [1:0] HDB3_POS  = 2'b01;
  localparam logic [1:0] HDB3_NEG  = 2'b10;

  // Terminal value of the zero-run counter: the fourth zero becomes V.
  localparam logic [1:0] ZCNT_MAX = 2'd3;

  // Mark carried through the encoder pipeline, one per input bit.
  typedef enum logic [1:0] {
    MARK_ZERO = 2'b00,
    MARK_ONE  = 2'b01,
    MARK_V    = 2'b10,
    MARK_B    = 2'b11
  } mark_t;

  // Polarity of the most recent nonzero symbol on the line.
  typedef enum logic {
    POL_NEG = 1'b0,
    POL_POS = 1'b1
  } pol_t;

  // Symbol code for a pulse of the given polarity.
  function automatic logic [1:0] pol_code(input pol_t pol);
    return (pol == POL_POS) ? HDB3_POS : HDB3_NEG;
  endfunction

  // Opposite polarity, used for ONE and B pulses.
  function automatic pol_t pol_flip(input pol_t pol);
    return (pol == POL_POS) ? POL_NEG : POL_POS;
  endfunction

endpackage

// File: rtl/hdb3_polarity.sv
// HDB3 polarity stage: turns the oldest pipeline mark into a registered
// ternary symbol. ONE and B alternate polarity; V repeats the previous
// polarity so the decoder can recognise it as a violation.
module hdb3_polarity
  import hdb3_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  mark_t      mark,
  output logic [1:0] code
);

  pol_t       last_pol_q;
  pol_t       last_pol_d;
  logic [1:0] code_d;

  // Symbol and polarity update for the mark leaving the pipeline.
  always_comb begin
    last_pol_d = last_pol_q;
    code_d     = HDB3_ZERO;
    unique case (mark)
      MARK_ONE, MARK_B: begin
        last_pol_d = pol_flip(last_pol_q);
        code_d     = pol_code(pol_flip(last_pol_q));
      end
      MARK_V: begin
        code_d = pol_code(last_pol_q);
      end
      MARK_ZERO: begin
        code_d = HDB3_ZERO;
      end
    endcase
  end

  // Registered output symbol and last-pulse polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pol_q <= POL_NEG;
      code       <= HDB3_ZERO;
    end else begin
      last_pol_q <= last_pol_d;
      code       <= code_d;
    end
  end

endmodule

// File: rtl/hdb3_encode.sv
// Serial NRZ-to-HDB3 line encoder. One bit in and one ternary symbol out
// per clock with a fixed 4-cycle latency. Every run of four zeros is
// replaced by 000V (odd pulse count since last V) or B00V (even).
// Optional build macro HDB3_ENCODE_AMI_EN adds i_ami_mode, which
// bypasses substitution and yields plain AMI.
module hdb3_encode
  import hdb3_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_data,
`ifdef HDB3_ENCODE_AMI_EN
  input  logic       i_ami_mode,
`endif
  output logic [1:0] o_hdb3_code
);

  mark_t      mark_q [4];
  mark_t      new_mark;
  logic [1:0] zcnt_q;
  logic [1:0] zcnt_d;
  logic       parity_q;
  logic       parity_d;
  logic       sub_b;
  logic       ami_mode;

`ifdef HDB3_ENCODE_AMI_EN
  assign ami_mode = i_ami_mode;
`else
  assign ami_mode = 1'b0;
`endif

  // Classify the incoming bit and advance the zero counter and parity.
  // The B decision is taken on the edge V enters: the first zero of the
  // run is then exactly the entry moving from mark_q[2] to mark_q[3].
  always_comb begin
    new_mark = MARK_ZERO;
    zcnt_d   = zcnt_q;
    parity_d = parity_q;
    sub_b    = 1'b0;
    if (ami_mode) begin
      new_mark = i_data ? MARK_ONE : MARK_ZERO;
      zcnt_d   = '0;
      parity_d = 1'b0;
    end else if (i_data) begin
      new_mark = MARK_ONE;
      zcnt_d   = '0;
      parity_d = ~parity_q;
    end else if (zcnt_q == ZCNT_MAX) begin
      new_mark = MARK_V;
      zcnt_d   = '0;
      parity_d = 1'b0;
      sub_b    = ~parity_q;
    end else begin
      new_mark = MARK_ZERO;
      zcnt_d   = zcnt_q + 2'd1;
    end
  end

  // Zero-run counter and pulse parity since the last violation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zcnt_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      zcnt_q   <= zcnt_d;
      parity_q <= parity_d;
    end
  end

  // Four-deep mark pipeline with in-flight B rewrite at the tail.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        mark_q[i] <= MARK_ZERO;
      end
    end else begin
      mark_q[0] <= new_mark;
      mark_q[1] <= mark_q[0];
      mark_q[2] <= mark_q[1];
      mark_q[3] <= sub_b ? MARK_B : mark_q[2];
    end
  end

  hdb3_polarity u_polarity (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .mark  (mark_q[3]),
    .code  (o_hdb3_code)
  );

endmodule

// File: tb/tb_hdb3_encode.sv
// Self-checking bench for hdb3_encode: directed vector table, mid-run
// reset sequence, and random data against a sequence-level HDB3 model
// plus an independent decode of the produced line stream.
module tb_hdb3_encode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data = 1'b0;
  logic [1:0] code;
`ifdef HDB3_ENCODE_AMI_EN
  logic       ami = 1'b0;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;

  bit         stim [0:1023];
  int unsigned nstim = 0;
  logic [1:0] cap [0:1023];
  logic [1:0] expsym [0:1023];

  typedef struct {
    string bits;
    string exp;
  } vec_t;

  vec_t vecs [5];

  hdb3_encode dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data      (data),
`ifdef HDB3_ENCODE_AMI_EN
    .i_ami_mode  (ami),
`endif
    .o_hdb3_code (code)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp_lo, input int exp_hi);
    total++;
    if (got < exp_lo || got > exp_hi) begin
      bad++;
      $display("FAIL %s got=%0d exp=[%0d..%0d]", name, got, exp_lo, exp_hi);
    end
  endtask

  function automatic logic [1:0] sym_of(input byte c);
    if (c == "+") return 2'b01;
    if (c == "-") return 2'b10;
    return 2'b00;
  endfunction

  task automatic load_bits(input string s);
    nstim = s.len();
    for (int i = 0; i < s.len(); i++) stim[i] = (s[i] == "1");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    data  = 1'b0;
    #1 check("reset_code", code, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Edge i samples stim[i] (zero beyond the stimulus); cap[i] is the
  // symbol seen just after edge i.
  task automatic run_edges(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      data = (i < nstim) ? stim[i] : 1'b0;
      @(posedge clk);
      #1;
      cap[i] = code;
    end
    data = 1'b0;
  endtask

  task automatic check_string(input string tag, input string exp);
    for (int j = 0; j < exp.len(); j++)
      check($sformatf("%s_sym%0d", tag, j), cap[j], sym_of(exp[j]));
  endtask

  // Whole-sequence HDB3 rule: fourth zero of a run becomes V; if the
  // pulse count since the previous V is even, the run's first zero
  // becomes B. Then pulses alternate, V repeats the last polarity.
  task automatic build_model(input int n);
    int m [0:1023];
    int zc;
    int ones;
    int last;
    int s;
    zc = 0;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      if (stim[i]) begin
        m[i] = 1;
        zc = 0;
        ones++;
      end else begin
        zc++;
        m[i] = 0;
        if (zc == 4) begin
          m[i] = 2;
          if (ones % 2 == 0) m[i-3] = 3;
          ones = 0;
          zc = 0;
        end
      end
    end
    for (int i = 0; i < 4; i++) expsym[i] = 2'b00;
    last = -1;
    for (int i = 0; i < n; i++) begin
      s = 0;
      if (m[i] == 1 || m[i] == 3) begin
        last = -last;
        s = last;
      end else if (m[i] == 2) begin
        s = last;
      end
      expsym[i+4] = (s > 0) ? 2'b01 : (s < 0) ? 2'b10 : 2'b00;
    end
  endtask

  initial begin
    vecs[0].bits = "1";         vecs[0].exp = "0000+";
    vecs[1].bits = "1111";      vecs[1].exp = "0000+-+-";
    vecs[2].bits = "000010000"; vecs[2].exp = "0000+00+-000-";
    vecs[3].bits = "110000";    vecs[3].exp = "0000+-+00+";
    vecs[4].bits = "00000000";  vecs[4].exp = "0000+00+-00-";

    // Directed vector table.
    for (int v = 0; v < 5; v++) begin
      load_bits(vecs[v].bits);
      do_reset();
      run_edges(vecs[v].exp.len());
      check_string($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Reset in the middle of a pending violation run.
    load_bits("1000");
    do_reset();
    run_edges(5);
    check("pre_reset_pulse", cap[4], 2'b01);
    #3 rst_n = 1'b0;
    #1 check("async_reset", code, 2'b00);
    @(posedge clk);
    #1 check("held_reset", code, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    load_bits("10000");
    run_edges(9);
    check_string("midreset", "0000+000+");

    // Random data against the sequence model.
    begin
      int n;
      int run;
      int maxrun;
      int errs;
      logic [1:0] lastnz;
      bit dec [0:1023];
      n = 600;
      nstim = n;
      for (int i = 0; i < n; i++) stim[i] = ($urandom_range(0, 2) == 0);
      do_reset();
      run_edges(n + 4);
      build_model(n);
      for (int i = 0; i < n + 4; i++)
        check($sformatf("rand_sym%0d", i), cap[i], expsym[i]);

      run = 0;
      maxrun = 0;
      for (int i = 4; i < n + 4; i++) begin
        run = (cap[i] == 2'b00) ? run + 1 : 0;
        if (run > maxrun) maxrun = run;
      end
      check_int("max_zero_run", maxrun, 0, 3);

      // Independent decode: a pulse matching the previous pulse's polarity
      // is a violation and clears itself and the three symbols before it.
      errs = 0;
      lastnz = 2'b00;
      for (int i = 0; i < n; i++) begin
        dec[i] = (cap[i+4] != 2'b00);
        if (cap[i+4] != 2'b00) begin
          if (cap[i+4] == lastnz && i >= 3)
            for (int k = i - 3; k <= i; k++) dec[k] = 1'b0;
          lastnz = cap[i+4];
        end
      end
      for (int i = 0; i < n; i++) if (dec[i] != stim[i]) errs++;
      check_int("loopback_errs", errs, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
